// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: RX deserializer state encoding,
//                parity-mode constants and a parity helper used by both the
//                RX deserializer and the TX serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } rx_deser_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Reduction XOR over a zero-extended vector; callers cast to 16 bits.
    function automatic logic parity_of(input logic [15:0] v);
        return ^v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_counter
//  Description : Saturating up-counter with synchronous clear and enable.
//                o_terminal flags the enabled cycle on which the count
//                reaches MAX_COUNT, so a caller can change state on that
//                same edge.
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                i_clr      - clear count to zero (wins over i_en)
//                i_en       - advance count by one
//                o_terminal - this enable brings the count to MAX_COUNT
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_counter #(
    parameter int MAX_COUNT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_terminal
);

    localparam int                 c_cnt_w = $clog2(MAX_COUNT + 1);
    localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_COUNT);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(MAX_COUNT - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count_q;
    logic [c_cnt_w-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_clr) begin
            w_count_d = '0;
        end else if (i_en && (r_count_q != c_max)) begin
            // Saturate at MAX_COUNT: never wraps back to zero.
            w_count_d = r_count_q + c_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_terminal = i_en && !i_clr && (r_count_q == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_deser_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_deser_param
//  Description : Parametrised UART RX deserializer. Shifts in DATA_W sampled
//                bits (optionally followed by one parity bit) and presents
//                the aligned word with a one-cycle valid pulse.
//  Ports       : clk         - clock, rising edge
//                rst_n       - asynchronous active-low reset
//                frame_start - arms a new frame (aborts any frame in flight)
//                bit_strobe  - sampled_bit is valid this cycle
//                sampled_bit - serial data bit
//                par_en      - parity bit follows data (latched at frame_start)
//                par_odd     - odd parity when 1 (latched at frame_start)
//                p_data      - assembled word, held until next p_valid
//                p_valid     - one-cycle pulse, p_data/par_err updated
//                par_err     - parity mismatch for word in p_data
//                busy        - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deser_param
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              bit_strobe,
    input  logic              sampled_bit,
    input  logic              par_en,
    input  logic              par_odd,
    output logic [DATA_W-1:0] p_data,
    output logic              p_valid,
    output logic              par_err,
    output logic              busy
);

    rx_deser_state_t   r_state_q, w_state_d;
    logic [DATA_W-1:0] r_sr_q, w_sr_d;
    logic [DATA_W-1:0] r_data_q, w_data_d;
    logic [DATA_W-1:0] w_sr_shift;
    logic              r_acc_q, w_acc_d;
    logic              r_err_q, w_err_d;
    logic              r_cfg_en_q, w_cfg_en_d;
    logic              r_cfg_odd_q, w_cfg_odd_d;
    logic              r_valid_q, w_valid_d;
    logic              r_perr_q, w_perr_d;

    logic w_strobe;
    logic w_cnt_en;
    logic w_cnt_last;

    // A strobe coinciding with frame_start belongs to no frame and is dropped.
    assign w_strobe = bit_strobe && !frame_start;
    assign w_cnt_en = (r_state_q == DATA) && w_strobe;

    uart_bit_counter #(
        .MAX_COUNT (DATA_W)
    ) u_bit_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (frame_start),
        .i_en       (w_cnt_en),
        .o_terminal (w_cnt_last)
    );

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_sr_shift = {sampled_bit, r_sr_q[DATA_W-1:1]};
        end else begin : g_msb_first
            assign w_sr_shift = {r_sr_q[DATA_W-2:0], sampled_bit};
        end
    endgenerate

    always_comb begin
        w_state_d   = r_state_q;
        w_sr_d      = r_sr_q;
        w_acc_d     = r_acc_q;
        w_err_d     = r_err_q;
        w_cfg_en_d  = r_cfg_en_q;
        w_cfg_odd_d = r_cfg_odd_q;
        w_data_d    = r_data_q;
        w_perr_d    = r_perr_q;
        w_valid_d   = 1'b0;

        unique case (r_state_q)
            IDLE: begin
            end
            DATA: begin
                if (w_strobe) begin
                    w_sr_d  = w_sr_shift;
                    w_acc_d = r_acc_q ^ sampled_bit;
                    if (w_cnt_last) begin
                        w_state_d = r_cfg_en_q ? PARITY : DONE;
                    end
                end
            end
            PARITY: begin
                if (w_strobe) begin
                    w_err_d   = parity_of(16'({r_acc_q, sampled_bit,
                                               (r_cfg_odd_q == PAR_ODD)}));
                    w_state_d = DONE;
                end
            end
            DONE: begin
                w_valid_d = 1'b1;
                w_data_d  = r_sr_q;
                w_perr_d  = r_err_q;
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Arming overrides the frame state only; a completing DONE still
        // publishes its word above.
        if (frame_start) begin
            w_state_d   = DATA;
            w_sr_d      = '0;
            w_acc_d     = 1'b0;
            w_err_d     = 1'b0;
            w_cfg_en_d  = par_en;
            w_cfg_odd_d = par_odd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q   <= IDLE;
            r_sr_q      <= '0;
            r_acc_q     <= 1'b0;
            r_err_q     <= 1'b0;
            r_cfg_en_q  <= 1'b0;
            r_cfg_odd_q <= PAR_EVEN;
            r_data_q    <= '0;
            r_perr_q    <= 1'b0;
            r_valid_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_sr_q      <= w_sr_d;
            r_acc_q     <= w_acc_d;
            r_err_q     <= w_err_d;
            r_cfg_en_q  <= w_cfg_en_d;
            r_cfg_odd_q <= w_cfg_odd_d;
            r_data_q    <= w_data_d;
            r_perr_q    <= w_perr_d;
            r_valid_q   <= w_valid_d;
        end
    end

    assign p_data  = r_data_q;
    assign p_valid = r_valid_q;
    assign par_err = r_perr_q;
    assign busy    = (r_state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deser_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_deser_param
//  Description : Self-checking bench for uart_rx_deser_param. Three instances
//                (8-bit LSB-first, 8-bit MSB-first, 5-bit LSB-first) share one
//                stimulus stream; a frame-level model collects received bits
//                and derives the expected word and parity error.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deser_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start, bit_strobe, sampled_bit, par_en, par_odd;
    logic [7:0] p_data0, p_data1;
    logic [4:0] p_data2;
    logic [2:0] p_valid, par_err, busy;

    always #5 clk = ~clk;

    uart_rx_deser_param #(.DATA_W(8), .LSB_FIRST(1'b1)) u_dut_lsb8 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_strobe(bit_strobe),
        .sampled_bit(sampled_bit), .par_en(par_en), .par_odd(par_odd),
        .p_data(p_data0), .p_valid(p_valid[0]), .par_err(par_err[0]), .busy(busy[0]));

    uart_rx_deser_param #(.DATA_W(8), .LSB_FIRST(1'b0)) u_dut_msb8 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_strobe(bit_strobe),
        .sampled_bit(sampled_bit), .par_en(par_en), .par_odd(par_odd),
        .p_data(p_data1), .p_valid(p_valid[1]), .par_err(par_err[1]), .busy(busy[1]));

    uart_rx_deser_param #(.DATA_W(5), .LSB_FIRST(1'b1)) u_dut_lsb5 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_strobe(bit_strobe),
        .sampled_bit(sampled_bit), .par_en(par_en), .par_odd(par_odd),
        .p_data(p_data2), .p_valid(p_valid[2]), .par_err(par_err[2]), .busy(busy[2]));

    // Per-instance configuration seen by the model
    int c_w   [3] = '{8, 8, 5};
    bit c_lsb [3] = '{1'b1, 1'b0, 1'b1};

    // Frame-level model state
    bit         m_active   [3];
    bit         m_complete [3];
    bit         m_en       [3];
    bit         m_odd      [3];
    bit         m_bits     [3][10];
    int         m_n        [3];
    logic [8:0] e_data     [3];
    logic       e_valid    [3];
    logic       e_err      [3];
    logic       e_busy     [3];

    int n_checks = 0;
    int n_fail   = 0;
    int vcount [3];

    typedef struct {
        bit       fs, st, b, pe, po;
        bit       e_valid;
        logic [7:0] e_data;
        bit       e_err;
        bit       e_busy;
    } vec_t;
    vec_t tbl[$];

    function automatic void chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [8:0] dut_data(input int d);
        case (d)
            0:       return {1'b0, p_data0};
            1:       return {1'b0, p_data1};
            default: return {4'b0, p_data2};
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_active[d] = 0; m_complete[d] = 0; m_en[d] = 0; m_odd[d] = 0; m_n[d] = 0;
            e_data[d] = '0; e_valid[d] = 0; e_err[d] = 0; e_busy[d] = 0;
        end
    endtask

    // Applied once per rising edge with the inputs that edge samples.
    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            bit was;
            was = m_complete[d];
            e_valid[d] = 1'b0;
            if (was) begin
                logic [8:0] w;
                bit         p;
                w = '0;
                p = 1'b0;
                for (int i = 0; i < m_n[d]; i++) begin
                    p ^= m_bits[d][i];
                    if (i < c_w[d]) begin
                        if (c_lsb[d]) w[i] = m_bits[d][i];
                        else          w[c_w[d]-1-i] = m_bits[d][i];
                    end
                end
                e_valid[d]    = 1'b1;
                e_data[d]     = w;
                e_err[d]      = m_en[d] ? (p ^ m_odd[d]) : 1'b0;
                m_complete[d] = 0;
                m_active[d]   = 0;
            end
            if (frame_start) begin
                m_active[d]   = 1;
                m_complete[d] = 0;
                m_n[d]        = 0;
                m_en[d]       = par_en;
                m_odd[d]      = par_odd;
            end else if (m_active[d] && !was && bit_strobe) begin
                m_bits[d][m_n[d]] = sampled_bit;
                m_n[d]++;
                if (m_n[d] == c_w[d] + int'(m_en[d])) m_complete[d] = 1;
            end
            e_busy[d] = m_active[d];
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("valid[%0d]", d), {8'b0, p_valid[d]}, {8'b0, e_valid[d]});
            chk($sformatf("data[%0d]", d),  dut_data(d),        e_data[d]);
            chk($sformatf("err[%0d]", d),   {8'b0, par_err[d]}, {8'b0, e_err[d]});
            chk($sformatf("busy[%0d]", d),  {8'b0, busy[d]},    {8'b0, e_busy[d]});
            vcount[d] += int'(p_valid[d]);
        end
    endtask

    task automatic step(input bit fs, input bit st, input bit b, input bit pe, input bit po);
        frame_start = fs; bit_strobe = st; sampled_bit = b; par_en = pe; par_odd = po;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // bits_v[i] is the i-th bit on the wire; random idle gaps between strobes.
    task automatic send_frame(input logic [8:0] bits_v, input int n, input bit pe, input bit po);
        step(1, 0, 0, pe, po);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step(0, 0, 0, 0, 0);
            step(0, 1, bits_v[i], 0, 0);
        end
    endtask

    function automatic void add_row(input bit fs, input bit st, input bit b, input bit pe,
                                    input bit po, input bit ev, input logic [7:0] ed,
                                    input bit ee, input bit eb);
        vec_t v;
        v.fs = fs; v.st = st; v.b = b; v.pe = pe; v.po = po;
        v.e_valid = ev; v.e_data = ed; v.e_err = ee; v.e_busy = eb;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;

        // Frame A5, no parity; a stray strobe while idle is ignored
        add_row(1, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 8; i++) add_row(0, 1, a5[i], 0, 0, 0, 8'h00, 0, 1);
        add_row(0, 0, 0, 0, 0, 1, 8'hA5, 0, 0);
        add_row(0, 1, 1, 0, 0, 0, 8'hA5, 0, 0);
        // Frame A5, even parity, parity bit 1 -> error; par_en latched only at arming
        add_row(1, 0, 0, 1, 0, 0, 8'hA5, 0, 1);
        for (int i = 0; i < 8; i++) add_row(0, 1, a5[i], 0, 0, 0, 8'hA5, 0, 1);
        add_row(0, 1, 1, 0, 0, 0, 8'hA5, 0, 1);
        add_row(0, 0, 0, 0, 0, 1, 8'hA5, 1, 0);
        add_row(0, 0, 0, 0, 0, 0, 8'hA5, 1, 0);
        // Same with parity bit 0 -> no error
        add_row(1, 0, 0, 1, 0, 0, 8'hA5, 1, 1);
        for (int i = 0; i < 8; i++) add_row(0, 1, a5[i], 0, 0, 0, 8'hA5, 1, 1);
        add_row(0, 1, 0, 0, 0, 0, 8'hA5, 1, 1);
        add_row(0, 0, 0, 0, 0, 1, 8'hA5, 0, 0);

        // Reset
        rst_n = 1'b0;
        frame_start = 0; bit_strobe = 0; sampled_bit = 0; par_en = 0; par_odd = 0;
        model_reset();
        for (int d = 0; d < 3; d++) vcount[d] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Table-driven directed frames
        for (int r = 0; r < tbl.size(); r++) begin
            step(tbl[r].fs, tbl[r].st, tbl[r].b, tbl[r].pe, tbl[r].po);
            chk($sformatf("tbl%0d_valid", r), {8'b0, p_valid[0]}, {8'b0, tbl[r].e_valid});
            chk($sformatf("tbl%0d_data", r),  {1'b0, p_data0},    {1'b0, tbl[r].e_data});
            chk($sformatf("tbl%0d_err", r),   {8'b0, par_err[0]}, {8'b0, tbl[r].e_err});
            chk($sformatf("tbl%0d_busy", r),  {8'b0, busy[0]},    {8'b0, tbl[r].e_busy});
        end

        // Bit order: 1,1,0,0,0,0,0,0 -> 0x03 LSB-first, 0xC0 MSB-first
        send_frame(9'h003, 8, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("order_valid", {8'b0, p_valid[0]}, 9'h001);
        chk("order_lsb",   {1'b0, p_data0},    9'h003);
        chk("order_msb",   {1'b0, p_data1},    9'h0C0);

        // 5-bit odd parity: bits 1,1,1,0,0 (three ones)
        send_frame(9'h007, 6, 1, 1);
        step(0, 0, 0, 0, 0);
        chk("w5_valid",  {8'b0, p_valid[2]}, 9'h001);
        chk("w5_data",   {4'b0, p_data2},    9'h007);
        chk("w5_err_p0", {8'b0, par_err[2]}, 9'h000);
        send_frame(9'h027, 6, 1, 1);
        step(0, 0, 0, 0, 0);
        chk("w5_err_p1", {8'b0, par_err[2]}, 9'h001);

        // Abort after 4 strobes, then a full 0x3C frame
        for (int d = 0; d < 3; d++) vcount[d] = 0;
        send_frame(9'h1FF, 4, 0, 0);
        chk("abort_hold", {1'b0, p_data0}, 9'h003);
        send_frame(9'h03C, 8, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("abort_data",   {1'b0, p_data0}, 9'h03C);
        chk("abort_pulses", 9'(vcount[0]),   9'd1);

        // frame_start with a strobe in the same cycle: that bit is dropped
        step(1, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, a5[i] ^ a5[7-i] ^ (i[0] ? 1'b0 : 1'b1) ^ 1'b1 ? 1'b0 : 1'b0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("fs_strobe_valid", {8'b0, p_valid[0]}, 9'h001);
        chk("fs_strobe_data",  {1'b0, p_data0},    9'h000);
        // Second same-cycle case with a non-zero word 0x5A
        begin
            logic [7:0] w5a;
            w5a = 8'h5A;
            step(1, 1, 1, 0, 0);
            for (int i = 0; i < 8; i++) step(0, 1, w5a[i], 0, 0);
            step(0, 0, 0, 0, 0);
            chk("fs_strobe_5a", {1'b0, p_data0}, 9'h05A);
        end

        // Asynchronous reset mid-frame, away from any clock edge
        step(1, 0, 0, 1, 1);
        repeat (5) step(0, 1, 1, 0, 0);
        frame_start = 0; bit_strobe = 0; sampled_bit = 0; par_en = 0; par_odd = 0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_data[%0d]", d),  dut_data(d),        9'h000);
            chk($sformatf("rst_valid[%0d]", d), {8'b0, p_valid[d]}, 9'h000);
            chk($sformatf("rst_err[%0d]", d),   {8'b0, par_err[d]}, 9'h000);
            chk($sformatf("rst_busy[%0d]", d),  {8'b0, busy[d]},    9'h000);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Strobes with no frame_start produce nothing
        for (int d = 0; d < 3; d++) vcount[d] = 0;
        repeat (12) step(0, 1, 1, 0, 0);
        for (int d = 0; d < 3; d++) chk($sformatf("no_arm_pulses[%0d]", d), 9'(vcount[d]), 9'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
